// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the skid pipeline stage: state encoding and default width.
package pipe_defs;

    localparam int unsigned DEF_WIDTH = 4;

    // Values double as the occupancy count; 2'd3 is unused and recovers to EMPTY.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry valid/ready skid stage; in_ready is decoded from registered state only.
module pipe_skid_stage
    import pipe_defs::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    skid_state_t      state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;
    logic             out_fire;

    always_comb begin
        out_valid = (state == ONE) || (state == TWO);
        in_ready  = !rst && ((state == EMPTY) || (state == ONE));
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        out_data  = main_q;
        occupancy = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_q <= in_data;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        skid_q <= in_data;
                        state  <= TWO;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (out_valid && !out_ready),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage using a queue-based reference model.
module tb_pipe_skid_stage;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;

    pipe_skid_stage #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int unsigned     checks = 0;
    int unsigned     errors = 0;
    logic [WIDTH-1:0] q[$];
    int unsigned     m_stall = 0;

    function automatic void check(string name, int unsigned act, int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic step(input logic r, input logic iv, input logic [WIDTH-1:0] d,
                        input logic ordy);
        bit m_in_fire;
        bit m_out_fire;
        rst       = r;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_stall = 0;
        end else begin
            m_in_fire  = iv && (q.size() < 2);
            m_out_fire = (q.size() > 0) && ordy;
            if ((q.size() > 0) && !ordy && (m_stall < CNT_MAX)) m_stall++;
            if (m_out_fire) void'(q.pop_front());
            if (m_in_fire) q.push_back(d);
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("occupancy", 32'(occupancy), q.size());
        check("in_ready", 32'(in_ready), 32'(!r && (q.size() < 2)));
        check("stall_cnt", 32'(stall_cnt), m_stall);
        if (q.size() > 0) check("out_data", 32'(out_data), 32'(q[0]));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset then idle
        step(1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_data", 32'(out_data), 0);
        step(1'b0, 1'b0, 4'd0, 1'b0);
        check("idle_in_ready", 32'(in_ready), 1);
        check("idle_occ", 32'(occupancy), 0);

        // Single word
        step(1'b0, 1'b1, 4'b1001, 1'b1);
        check("single_valid", 32'(out_valid), 1);
        check("single_data", 32'(out_data), 9);
        step(1'b0, 1'b0, 4'd0, 1'b1);
        check("single_drain", 32'(occupancy), 0);

        // Streaming 1..8
        for (int unsigned k = 1; k <= 8; k++) begin
            step(1'b0, 1'b1, 4'(k), 1'b1);
            check("stream_data", 32'(out_data), k);
            check("stream_occ", 32'(occupancy), 1);
            check("stream_ready", 32'(in_ready), 1);
        end
        step(1'b0, 1'b0, 4'd0, 1'b1);

        // Backpressure
        step(1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b1, 4'd5, 1'b0);
        check("bp_occ1", 32'(occupancy), 1);
        step(1'b0, 1'b1, 4'd6, 1'b0);
        check("bp_occ2", 32'(occupancy), 2);
        check("bp_in_ready", 32'(in_ready), 0);
        step(1'b0, 1'b1, 4'd7, 1'b0);
        check("bp_hold5", 32'(out_data), 5);
        check("bp_stall", 32'(stall_cnt), 2);
        step(1'b0, 1'b1, 4'd7, 1'b1);
        check("bp_out6", 32'(out_data), 6);
        step(1'b0, 1'b1, 4'd7, 1'b1);
        check("bp_out7", 32'(out_data), 7);
        step(1'b0, 1'b0, 4'd0, 1'b1);
        check("bp_empty", 32'(occupancy), 0);

        // Saturation
        step(1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b1, 4'd3, 1'b0);
        for (int unsigned k = 0; k < 20; k++) step(1'b0, 1'b0, 4'd0, 1'b0);
        check("sat_cnt", 32'(stall_cnt), 15);

        // Reset mid-operation from TWO
        step(1'b0, 1'b1, 4'd4, 1'b0);
        check("mid_two", 32'(occupancy), 2);
        step(1'b1, 1'b1, 4'd8, 1'b1);
        check("mid_occ", 32'(occupancy), 0);
        check("mid_valid", 32'(out_valid), 0);
        step(1'b0, 1'b1, 4'hA, 1'b0);
        check("mid_first", 32'(out_data), 10);
        check("mid_alone", 32'(occupancy), 1);
        step(1'b0, 1'b0, 4'd0, 1'b1);
        check("mid_drain", 32'(occupancy), 0);

        // Randomized traffic
        for (int unsigned k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 63) == 0), 1'($urandom), 4'($urandom),
                 ($urandom_range(0, 3) != 0) ? 1'($urandom) : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Registered valid/ready pipeline stage that sits directly downstream of the two-register data pipeline.
- Consumes the registered data word, holds up to two words, and presents them to the next consumer with full throughput under backpressure.
- Decouples upstream timing from downstream `out_ready`: `in_ready` is driven purely from stage state, never combinationally from `out_ready`.
- Also maintains a saturating stall counter for debug visibility.

Parameters:
- `WIDTH`, 4, data word width in bits.
- `CNT_W`, 8, width of the stall counter.

Ports:
- `clk`  input  1  single clock; all state updates on posedge.
- `rst`  input  1  synchronous reset, active-high.
- `in_data`  input  WIDTH  upstream data word.
- `in_valid`  input  1  upstream word valid.
- `in_ready`  output  1  stage can accept a word this cycle.
- `out_data`  output  WIDTH  word presented downstream.
- `out_valid`  output  1  `out_data` holds a valid word.
- `out_ready`  input  1  downstream accepts `out_data` this cycle.
- `occupancy`  output  2  number of words held (0..2).
- `stall_cnt`  output  CNT_W  saturating count of cycles with `out_valid`=1 and `out_ready`=0.

Behaviour:
- Handshake fire conditions:
  - in_fire = `in_valid` & `in_ready`
  - out_fire = `out_valid` & `out_ready`
- Storage: main register (drives `out_data`) and skid register. Word order is strictly preserved, and no word is ever dropped or duplicated.
- States, encoded in `occupancy`:
  - EMPTY=0
  - ONE=1
  - TWO=2
  - Encoding 3 is illegal; if reached, the stage recovers to EMPTY on the next clock.
- EMPTY:
  - `out_valid`=0, `in_ready`=1.
  - in_fire -> main<=`in_data`, go to ONE.
- ONE:
  - `out_valid`=1, `in_ready`=1.
  - in_fire & out_fire -> main<=`in_data`, stay in ONE.
  - in_fire & !out_fire -> skid<=`in_data`, go to TWO.
  - !in_fire & out_fire -> go to EMPTY.
  - Neither -> hold.
- TWO:
  - `out_valid`=1, `in_ready`=0.
  - out_fire -> main<=skid, go to ONE.
  - Otherwise hold.
  - `in_valid` is ignored in TWO.
- Latency and throughput:
  - EMPTY to `out_valid`: 1 cycle after in_fire.
  - Sustained throughput: 1 word/cycle while `out_ready`=1.
  - `in_ready` depends only on registered state, not on `out_ready`.
- `out_valid` and `out_data` change only on clock edges. `out_data` holds its value while `out_valid`=1 and `out_ready`=0.
- `stall_cnt`:
  - Increments each cycle that `out_valid`=1 and `out_ready`=0.
  - Saturates at 2^CNT_W-1; no wrap-around.
- Reset (synchronous, sampled on posedge `clk`):
  - Resulting values: state=EMPTY, `out_valid`=0, `out_data`=0, skid=0, `occupancy`=0, `stall_cnt`=0.
  - While `rst`=1, `in_ready` is forced to 0 and `in_valid` is ignored.
  - Reset asserted mid-transfer discards held words. There is no partial completion.
- Simultaneous events: reset has priority over any fire.

Decomposition:
- Shared package/include (`pipe_defs`): state encodings EMPTY/ONE/TWO as localparams, and the default `WIDTH`.
- One natural sub-module: `sat_counter`, with ports `clk`, `rst`, `en`, `count`, and parameter `CNT_W`. It implements `stall_cnt`.
- Skid/main datapath and FSM stay in the top module.

Test Plan:
- Reset then idle:
  - Stimulus: `rst`=1 for 2 cycles, then `in_valid`=0.
  - Required response: `out_valid`=0, `occupancy`=0, `stall_cnt`=0, `in_ready`=0 during reset and 1 after.
- Single word:
  - Stimulus: `in_data`=4'b1001 with `in_valid` for 1 cycle, `out_ready`=1.
  - Required response: `out_valid`=1 with `out_data`=4'b1001 exactly one cycle later, then `occupancy` returns to 0.
- Streaming:
  - Stimulus: words 1,2,3,...,8 on consecutive cycles, `out_ready`=1.
  - Required response: outputs 1..8 on consecutive cycles, `in_ready` stays 1, `occupancy` stays 1.
- Backpressure:
  - Stimulus: send 5,6,7 with `out_ready`=0.
  - Required response: `occupancy` goes 1 then 2 and `in_ready`=0, so 7 is not accepted. After `out_ready`=1, output order is 5,6, then 7 once accepted.
  - `stall_cnt` equals the number of stalled cycles.
- Saturation:
  - Stimulus: `CNT_W`=4, hold `out_ready`=0 with a word held for 20 cycles.
  - Required response: `stall_cnt` stops at 15.
- Reset mid-operation:
  - Stimulus: assert `rst` while in TWO.
  - Required response: the next cycle shows `occupancy`=0 and `out_valid`=0; the first post-reset word emerges alone, with no stale data.
